// File: rtl/bcd3_operand_order_if.sv
// Request/result bundle between the operand-ordering stage and its requester.
interface bcd3_operand_order_if;
    logic        start;
    logic        op;
    logic        a_sign;
    logic [11:0] a_bcd;
    logic        b_sign;
    logic [11:0] b_bcd;
    logic        busy;
    logic        done;
    logic        less;
    logic        equal;
    logic        greater;
    logic        eff_sub;
    logic        swap;
    logic        res_sign;
    logic        zero_res;
    logic        bcd_err;

    modport master (
        output start, op, a_sign, a_bcd, b_sign, b_bcd,
        input  busy, done, less, equal, greater, eff_sub, swap,
               res_sign, zero_res, bcd_err
    );

    modport slave (
        input  start, op, a_sign, a_bcd, b_sign, b_bcd,
        output busy, done, less, equal, greater, eff_sub, swap,
               res_sign, zero_res, bcd_err
    );
endinterface

// File: rtl/bcd3_operand_order.sv
// Operand-ordering stage for the signed 3-digit BCD adder/subtractor.
// Compares |A| and |B| one digit per cycle, MSD first, exiting at the first
// unequal digit, then decides effective operation, swap, sign and zero.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// CMP   | comparing digit idx of the captured operands
// DONE  | one-cycle done pulse; results already valid
module bcd3_operand_order #(
    parameter int NDIG = 3
) (
    input logic                  clk,
    input logic                  rst,
    bcd3_operand_order_if.slave  bus
);
    localparam int W = 4 * NDIG;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [1:0]   idx;
    logic         op_cap;
    logic         a_sign_cap;
    logic         b_sign_cap;
    logic [W-1:0] a_cap;
    logic [W-1:0] b_cap;
    logic         err_cap;

    logic less_r, equal_r, greater_r, eff_sub_r, swap_r, res_sign_r, zero_res_r, bcd_err_r;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic       dig_gt;
    logic       dig_lt;
    logic       finish;
    logic       eff_sub_c;
    logic       zero_c;
    logic       err_in;

    // select the digit under comparison and evaluate the exit decision
    always_comb begin
        a_dig = a_cap[3:0];
        b_dig = b_cap[3:0];
        case (idx)
            2'd2:    begin a_dig = a_cap[11:8]; b_dig = b_cap[11:8]; end
            2'd1:    begin a_dig = a_cap[7:4];  b_dig = b_cap[7:4];  end
            default: begin a_dig = a_cap[3:0];  b_dig = b_cap[3:0];  end
        endcase
        dig_gt    = a_dig > b_dig;
        dig_lt    = a_dig < b_dig;
        finish    = dig_gt | dig_lt | (idx == 2'd0);
        eff_sub_c = op_cap ^ a_sign_cap ^ b_sign_cap;
        // only meaningful on the finishing cycle, where equal digits mean equal magnitudes
        zero_c    = ~dig_gt & ~dig_lt & (eff_sub_c | (a_cap == '0));
    end

    // any of the six incoming digits outside 0..9
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.a_bcd[4*i +: 4] > 4'd9) err_in = 1'b1;
            if (bus.b_bcd[4*i +: 4] > 4'd9) err_in = 1'b1;
        end
    end

    // sequencer, operand capture and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            op_cap     <= 1'b0;
            a_sign_cap <= 1'b0;
            b_sign_cap <= 1'b0;
            a_cap      <= '0;
            b_cap      <= '0;
            err_cap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_cap     <= bus.op;
                        a_sign_cap <= bus.a_sign;
                        b_sign_cap <= bus.b_sign;
                        a_cap      <= bus.a_bcd;
                        b_cap      <= bus.b_bcd;
                        err_cap    <= err_in;
                        idx        <= 2'd2;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    if (finish) state <= DONE;
                    else        idx   <= idx - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // result registers, loaded only on the edge entering DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            less_r     <= 1'b0;
            equal_r    <= 1'b0;
            greater_r  <= 1'b0;
            eff_sub_r  <= 1'b0;
            swap_r     <= 1'b0;
            res_sign_r <= 1'b0;
            zero_res_r <= 1'b0;
            bcd_err_r  <= 1'b0;
        end else if (state == CMP && finish) begin
            less_r     <= dig_lt;
            equal_r    <= ~dig_lt & ~dig_gt;
            greater_r  <= dig_gt;
            eff_sub_r  <= eff_sub_c;
            swap_r     <= eff_sub_c & dig_lt;
            zero_res_r <= zero_c;
            bcd_err_r  <= err_cap;
            if (zero_c)                  res_sign_r <= 1'b0;
            else if (eff_sub_c & dig_lt) res_sign_r <= b_sign_cap ^ op_cap;
            else                         res_sign_r <= a_sign_cap;
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.less     = less_r;
    assign bus.equal    = equal_r;
    assign bus.greater  = greater_r;
    assign bus.eff_sub  = eff_sub_r;
    assign bus.swap     = swap_r;
    assign bus.res_sign = res_sign_r;
    assign bus.zero_res = zero_res_r;
    assign bus.bcd_err  = bcd_err_r;
endmodule

// File: tb/tb_bcd3_operand_order.sv
// Bench for bcd3_operand_order: directed cases plus randomized operands
// checked against an arithmetic model of the ordering rules.
module tb_bcd3_operand_order;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bcd3_operand_order_if bus ();

    bcd3_operand_order dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_word();
        return {22'd0, bus.busy, bus.done, bus.less, bus.equal, bus.greater,
                bus.eff_sub, bus.swap, bus.res_sign, bus.zero_res, bus.bcd_err};
    endfunction

    function automatic int digit(input int v, input int i);
        return (v >> (4 * i)) & 15;
    endfunction

    // Drive one request at a negedge and check latency and results.
    // hammer keeps start high while the block is busy.
    task automatic run_op(input bit op, input bit as, input int a,
                          input bit bs, input int b, input bit hammer);
        int  lat, n;
        bit  e_less, e_eq, e_gt, e_eff, e_swap, e_zero, e_sign, e_err;
        e_less = (a < b);
        e_eq   = (a == b);
        e_gt   = (a > b);
        e_eff  = as ^ bs ^ op;
        e_swap = e_eff & e_less;
        e_zero = e_eq & (e_eff | (a == 0));
        e_sign = e_zero ? 1'b0 : (e_swap ? (bs ^ op) : as);
        e_err  = 1'b0;
        for (int i = 0; i < 3; i++)
            if (digit(a, i) > 9 || digit(b, i) > 9) e_err = 1'b1;
        lat = 4;
        for (int i = 2; i >= 0; i--)
            if (digit(a, i) != digit(b, i)) begin
                lat = 4 - i;
                break;
            end

        bus.start  = 1'b1;
        bus.op     = op;
        bus.a_sign = as;
        bus.a_bcd  = a[11:0];
        bus.b_sign = bs;
        bus.b_bcd  = b[11:0];
        @(posedge clk);
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n = c;
            if (c == 1) begin
                bus.start  = hammer;
                bus.op     = 1'($urandom);
                bus.a_sign = 1'($urandom);
                bus.b_sign = 1'($urandom);
                bus.a_bcd  = 12'($urandom);
                bus.b_bcd  = 12'($urandom);
            end
            if (bus.done) break;
            chk("busy_in_cmp", bus.busy, 1);
            n = 9;
        end
        chk("latency", n, lat);
        chk("busy_at_done", bus.busy, 1);
        chk("less", bus.less, e_less);
        chk("equal", bus.equal, e_eq);
        chk("greater", bus.greater, e_gt);
        chk("eff_sub", bus.eff_sub, e_eff);
        chk("swap", bus.swap, e_swap);
        chk("res_sign", bus.res_sign, e_sign);
        chk("zero_res", bus.zero_res, e_zero);
        chk("bcd_err", bus.bcd_err, e_err);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
        chk("hold_less", bus.less, e_less);
        chk("hold_res_sign", bus.res_sign, e_sign);
    endtask

    // directed sequence followed by randomized operands
    initial begin
        int a, b;
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.a_sign = 1'b0;
        bus.b_sign = 1'b0;
        bus.a_bcd  = 12'h000;
        bus.b_bcd  = 12'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs_word(), 0);

        run_op(1'b0, 1'b0, 'h523, 1'b0, 'h498, 1'b0);
        run_op(1'b1, 1'b0, 'h123, 1'b0, 'h129, 1'b0);
        run_op(1'b0, 1'b1, 'h250, 1'b0, 'h250, 1'b0);
        run_op(1'b0, 1'b1, 'h000, 1'b1, 'h000, 1'b0);
        run_op(1'b0, 1'b0, 'h1A0, 1'b0, 'h190, 1'b1);

        // reset during the second CMP cycle of an all-equal compare
        bus.start  = 1'b1;
        bus.op     = 1'b0;
        bus.a_sign = 1'b0;
        bus.b_sign = 1'b0;
        bus.a_bcd  = 12'h777;
        bus.b_bcd  = 12'h777;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_midflight", outs_word(), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_done_after_reset", bus.done, 0);
        end
        run_op(1'b1, 1'b1, 'h305, 1'b0, 'h306, 1'b0);

        for (int t = 0; t < 40; t++) begin
            a = int'($urandom_range(0, 4095));
            b = a;
            if ($urandom_range(0, 3) != 0) b[11:8] = 4'($urandom);
            if ($urandom_range(0, 2) != 0) b[7:4]  = 4'($urandom);
            if ($urandom_range(0, 1) != 0) b[3:0]  = 4'($urandom);
            if ($urandom_range(0, 1) != 0) begin
                a = int'($urandom_range(0, 9)) * 256 + int'($urandom_range(0, 9)) * 16
                    + int'($urandom_range(0, 9));
                b = ($urandom_range(0, 2) == 0) ? a : (a ^ (1 << $urandom_range(0, 11)));
            end
            run_op(1'($urandom), 1'($urandom), a, 1'($urandom), b, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd3_operand_order.md
Name: bcd3_operand_order

Overview:
- Sequential operand-ordering stage that sits directly downstream of the 4-bit digit magnitude comparator. It sits in front of the signed 3-digit BCD adder/subtractor datapath.
- Walks two 3-digit BCD magnitudes one digit per cycle, MSD first, applying the same less/equal/greater rule the digit comparator uses. It exits early at the first unequal digit.
- From the comparison and the signs it decides:
  - effective operation (add or subtract),
  - whether the operands must be swapped,
  - the final result sign,
  - whether the result is zero.

Parameters:
- NDIG, 3, number of BCD digits per operand. Only 3 is verified; the digit index counter is 2 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = A+B, 1 = A-B
- a_sign  in  1  sign of A, 1 = negative
- a_bcd  in  12  magnitude of A, digit 2 in [11:8], digit 0 in [3:0]
- b_sign  in  1  sign of B
- b_bcd  in  12  magnitude of B
- busy  out  1  high in CMP and DONE
- done  out  1  one-cycle pulse; results valid from this cycle on
- less  out  1  |A| < |B|
- equal  out  1  |A| = |B|
- greater  out  1  |A| > |B|
- eff_sub  out  1  effective subtraction
- swap  out  1  datapath must compute B-A on magnitudes
- res_sign  out  1  sign of final result
- zero_res  out  1  result magnitude is 0
- bcd_err  out  1  some captured digit > 9

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - State goes to IDLE.
  - busy, done, less, equal, greater, eff_sub, swap, res_sign, zero_res and bcd_err all go to 0.
  - Overrides any operation in flight; no done is produced for it.
- States:
  - IDLE: on start=1, capture op, signs and both magnitudes into internal registers. Set idx=2, go to CMP. start is ignored in all other states.
  - CMP: compare captured digit idx of A and B as unsigned 4-bit values.
    - If A digit > B digit, or A digit < B digit: latch greater or less and go to DONE.
    - If the digits are equal and idx=0: latch equal=1 and go to DONE.
    - If the digits are equal and idx>0: decrement idx and stay in CMP.
  - DONE: done=1 for exactly this cycle, then return to IDLE.
- Latency, counted from the clock edge that samples start:
  - MSD differs: done is high in the 2nd cycle.
  - Digit 1 differs: done is high in the 3rd cycle.
  - Digit 0 differs or all digits equal: done is high in the 4th cycle.
  - Back-to-back operation: start may be asserted in the cycle after DONE.
- Exactly one of less, equal or greater is 1 after the first done, and all three are 0 before it.
- All result outputs update on the edge entering DONE. They then hold until the next entry into DONE or until reset.
- Decision rules, evaluated on the captured values:
  - eff_sub = a_sign XOR b_sign XOR op.
  - eff_sub=0: swap=0; res_sign=a_sign.
  - eff_sub=1 and greater=1: swap=0; res_sign=a_sign.
  - eff_sub=1 and less=1: swap=1; res_sign=b_sign XOR op.
  - eff_sub=1 and equal=1: swap=0.
  - zero_res=1 when (eff_sub=1 and equal=1), or when (equal=1 and captured A magnitude=0).
  - zero_res=1 forces res_sign=0; there is no negative zero.
- BCD check:
  - bcd_err is computed at capture and equals the OR over all six digits of (digit > 9).
  - It is reported on the DONE edge.
  - When bcd_err=1, the comparison still runs on raw 4-bit values.
- Input changes after capture have no effect on an operation in flight.

Test Plan:
1. Reset, then idle with start=0 -> all outputs 0 and busy=0.
2. MSD early exit: op=0, A=+0x523, B=+0x498 -> done high 2nd cycle after the start edge; greater=1, eff_sub=0, swap=0, res_sign=0, zero_res=0.
3. Swap case: op=1, A=+0x123, B=+0x129 -> done high 4th cycle; less=1, eff_sub=1, swap=1, res_sign=1.
4. Sign interplay and zero: op=0, A=-0x250, B=+0x250 -> done high 4th cycle; equal=1, eff_sub=1, zero_res=1, res_sign=0.
   - Separately: op=0, A=-0x000, B=-0x000 -> equal=1, eff_sub=0, zero_res=1, res_sign=0.
5. Invalid digit and busy: A=+0x1A0, B=+0x190 -> bcd_err=1 and greater=1 (done 3rd cycle).
   - start pulsed again while busy -> ignored, exactly one done pulse.
6. rst asserted in the 2nd CMP cycle of an all-equal compare -> next cycle IDLE, all outputs 0, no done.
   - A new start right after reset completes normally.
